perf_counter_bank: RTL and testbench

Parametrised bank of hardware performance counters (cycle, retired instructions, flushes, wait cycles, decoded instructions, and more) that generalises the fixed 64-bit counter set to N channels of configurable width. It sits beside the CSR unit: the core drives one event strobe per channel, and the CSR unit reads and writes counters through an XLEN-wide register port. Counters wider than XLEN are read in halves through a consistent low-then-high snapshot.

---
 rtl/perf_counter_bank.sv | 203 ++++++++++++++++++++
 tb/tb_perf_counter_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Bank of NUM_CNT event counters, each CNT_LEN bits wide, read and written
//   through an XLEN-wide register port. Counters twice as wide as XLEN are
//   read low half first; that read snapshots the high half so the following
//   high-half read returns a value consistent with the low half.
//
//   Register map (HALVES = CNT_LEN/XLEN):
//     k*HALVES+h        counter k, half h (h=0 low)
//     NUM_CNT*HALVES    INHIBIT, bit k freezes counter k
//     NUM_CNT*HALVES+1  OVF, sticky wrap flags, write-1-to-clear
//     others            read 0 with rd_err_o, writes ignored
//
//   Optional feature macro: PERF_CNT_OVF_IRQ_EN
//     defined   : OVF flags stored, irq_o = |OVF (registered)
//     undefined : OVF reads 0 (no error), writes ignored, irq_o = 0
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   inc_i[NUM_CNT]           per-channel event strobes
//   wr_en_i/addr/data        register write port
//   rd_en_i/addr             register read request
//   rd_data_o/valid/err      registered read response, 1-cycle latency
//   irq_o                    overflow interrupt request
module perf_counter_bank #(
  parameter int NUM_CNT = 5,
  parameter int CNT_LEN = 64,
  parameter int XLEN    = 32,
  parameter int CNT_INC = 1,
  parameter int ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] inc_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [XLEN-1:0]    wr_data_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [XLEN-1:0]    rd_data_o,
  output logic               rd_valid_o,
  output logic               rd_err_o,
  output logic               irq_o
);

  localparam int HALVES   = CNT_LEN / XLEN;
  localparam int INH_ADDR = NUM_CNT * HALVES;
  localparam int OVF_ADDR = INH_ADDR + 1;
  localparam bit SNAP     = (HALVES == 2);

  logic [CNT_LEN-1:0] cnt     [NUM_CNT];
  logic [CNT_LEN-1:0] cnt_sum [NUM_CNT];
  logic [NUM_CNT-1:0] wr_hit;
  logic [NUM_CNT-1:0] inc_ok;
  logic [NUM_CNT-1:0] inhibit;
  logic               wr_inh;

  logic [XLEN-1:0]    shadow;
  logic               shadow_vld;
  logic [3:0]         shadow_idx;
  logic               wr_to_shadow;

  logic [XLEN-1:0]    rd_val;
  logic [XLEN-1:0]    rd_cap;
  logic               rd_miss;
  logic               rd_lo_hit;
  logic               rd_hi_shadow;
  logic [3:0]         rd_cnt_idx;

`ifdef PERF_CNT_OVF_IRQ_EN
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] wrap;
  logic               wr_ovf;
  logic               irq_q;
`endif

  // Write decode and increment qualification
  always_comb begin
    wr_hit       = '0;
    wr_to_shadow = 1'b0;
    for (int k = 0; k < NUM_CNT; k++) begin
      for (int h = 0; h < HALVES; h++) begin
        if (wr_en_i && wr_addr_i == ADDR_W'(k * HALVES + h)) wr_hit[k] = 1'b1;
      end
      if (wr_hit[k] && shadow_idx == 4'(k)) wr_to_shadow = 1'b1;
      cnt_sum[k] = cnt[k] + CNT_LEN'(CNT_INC);
      // a write to the counter in the same cycle wins; the event is dropped
      inc_ok[k]  = inc_i[k] & ~inhibit[k] & ~wr_hit[k];
    end
    wr_inh = wr_en_i && wr_addr_i == ADDR_W'(INH_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CNT; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (wr_hit[k]) begin
          // address is k*HALVES+h, so bit 0 selects the half when HALVES=2
          if (HALVES == 1 || !wr_addr_i[0]) cnt[k][XLEN-1:0] <= wr_data_i;
          else                              cnt[k][CNT_LEN-1 -: XLEN] <= wr_data_i;
        end else if (inc_ok[k]) begin
          cnt[k] <= cnt_sum[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inhibit <= '0;
    else if (wr_inh) inhibit <= wr_data_i[NUM_CNT-1:0];
  end

`ifdef PERF_CNT_OVF_IRQ_EN
  always_comb begin
    wr_ovf = wr_en_i && wr_addr_i == ADDR_W'(OVF_ADDR);
    for (int k = 0; k < NUM_CNT; k++) wrap[k] = inc_ok[k] && (cnt_sum[k] < cnt[k]);
  end

  // a new wrap beats a simultaneous clear of the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf   <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ovf) ovf <= (ovf & ~wr_data_i[NUM_CNT-1:0]) | wrap;
      else        ovf <= ovf | wrap;
      irq_q <= |ovf;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux, sampled before this cycle's updates
  always_comb begin
    rd_val       = '0;
    rd_cap       = '0;
    rd_miss      = 1'b1;
    rd_lo_hit    = 1'b0;
    rd_hi_shadow = 1'b0;
    rd_cnt_idx   = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      for (int h = 0; h < HALVES; h++) begin
        if (rd_addr_i == ADDR_W'(k * HALVES + h)) begin
          rd_miss    = 1'b0;
          rd_cnt_idx = 4'(k);
          if (h == 0) begin
            rd_val    = cnt[k][XLEN-1:0];
            rd_cap    = cnt[k][CNT_LEN-1 -: XLEN];
            rd_lo_hit = 1'b1;
          end else if (shadow_vld && shadow_idx == 4'(k)) begin
            rd_val       = shadow;
            rd_hi_shadow = 1'b1;
          end else begin
            rd_val = cnt[k][CNT_LEN-1 -: XLEN];
          end
        end
      end
    end
    if (rd_addr_i == ADDR_W'(INH_ADDR)) begin
      rd_val  = XLEN'(inhibit);
      rd_miss = 1'b0;
    end
    if (rd_addr_i == ADDR_W'(OVF_ADDR)) begin
`ifdef PERF_CNT_OVF_IRQ_EN
      rd_val  = XLEN'(ovf);
`else
      rd_val  = '0;
`endif
      rd_miss = 1'b0;
    end
  end

  // High-half snapshot; a fresh low read always re-arms it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      shadow_vld <= 1'b0;
      shadow_idx <= '0;
    end else if (SNAP && rd_en_i && rd_lo_hit) begin
      shadow     <= rd_cap;
      shadow_vld <= 1'b1;
      shadow_idx <= rd_cnt_idx;
    end else if (wr_to_shadow || (rd_en_i && rd_hi_shadow)) begin
      shadow_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      rd_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      rd_err_o   <= rd_en_i & rd_miss;
      if (rd_en_i) rd_data_o <= rd_val;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  inc_i;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PERF_CNT_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [5:0]  addr;
    logic [31:0] exp_data;
    logic        exp_err;
  } rd_vec_t;

  rd_vec_t tbl[13];

  perf_counter_bank #(
    .NUM_CNT(5), .CNT_LEN(64), .XLEN(32), .CNT_INC(1), .ADDR_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc_i(inc_i),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_err_o(rd_err),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a,
                        input logic [31:0] exp, input logic exp_err);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    check({name, ".data"}, 64'(rd_data), 64'(exp));
    check({name, ".valid"}, 64'(rd_valid), 64'd1);
    check({name, ".err"}, 64'(rd_err), 64'(exp_err));
  endtask

  initial begin
    // state after: c0=15 c1=0x2_00000006 c2=0 c3=5 c4=5, INHIBIT=0b00100
    tbl[0]  = '{"c0_lo", 6'd0,  32'd15, 1'b0};
    tbl[1]  = '{"c0_hi", 6'd1,  32'd0,  1'b0};
    tbl[2]  = '{"c1_lo", 6'd2,  32'd6,  1'b0};
    tbl[3]  = '{"c1_hi", 6'd3,  32'd2,  1'b0};
    tbl[4]  = '{"c2_lo", 6'd4,  32'd0,  1'b0};
    tbl[5]  = '{"c2_hi", 6'd5,  32'd0,  1'b0};
    tbl[6]  = '{"c3_lo", 6'd6,  32'd5,  1'b0};
    tbl[7]  = '{"c3_hi", 6'd7,  32'd0,  1'b0};
    tbl[8]  = '{"c4_lo", 6'd8,  32'd5,  1'b0};
    tbl[9]  = '{"c4_hi", 6'd9,  32'd0,  1'b0};
    tbl[10] = '{"inhibit", 6'd10, 32'd4, 1'b0};
    tbl[11] = '{"unmapped12", 6'd12, 32'd0, 1'b1};
    tbl[12] = '{"unmapped63", 6'd63, 32'd0, 1'b1};

    rst_n = 1'b0; inc_i = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.data", 64'(rd_data), 64'd0);
    check("rst.valid", 64'(rd_valid), 64'd0);
    check("rst.err", 64'(rd_err), 64'd0);
    check("rst.irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    tick();

    // ten events on channel 0
    inc_i = 5'b00001;
    repeat (10) tick();
    inc_i = '0;
    rd_chk("cnt0_ten", 6'd0, 32'd10, 1'b0);
    tick();
    check("valid_one_cycle", 64'(rd_valid), 64'd0);
    check("data_hold", 64'(rd_data), 64'd10);

    // snapshot across a carry into the high half
    wr(6'd3, 32'h0000_0001);
    wr(6'd2, 32'hFFFF_FFFF);
    rd_chk("c1_lo_pre", 6'd2, 32'hFFFF_FFFF, 1'b0);
    inc_i = 5'b00010;
    repeat (2) tick();
    inc_i = '0;
    rd_chk("c1_hi_snapshot", 6'd3, 32'h0000_0001, 1'b0);
    rd_chk("c1_lo_fresh", 6'd2, 32'h0000_0001, 1'b0);
    rd_chk("c1_hi_fresh", 6'd3, 32'h0000_0002, 1'b0);

    // inhibit channel 2, strobe everything for 5 cycles
    wr(6'd10, 32'h0000_0004);
    inc_i = 5'b11111;
    repeat (5) tick();
    inc_i = '0;
    for (int i = 0; i < 13; i++) rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp_data, tbl[i].exp_err);
    wr(6'd10, 32'h0);

    // write beats a same-cycle increment
    wr_en = 1'b1; wr_addr = 6'd6; wr_data = 32'h55; inc_i = 5'b01000;
    tick();
    wr_en = 1'b0; inc_i = '0;
    rd_chk("c3_wr_prio_lo", 6'd6, 32'h55, 1'b0);
    rd_chk("c3_wr_prio_hi", 6'd7, 32'h0, 1'b0);

    // read and write same address in one cycle returns the old value
    wr_en = 1'b1; wr_addr = 6'd6; wr_data = 32'h77;
    rd_en = 1'b1; rd_addr = 6'd6;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdwr_same.data", 64'(rd_data), 64'h55);
    rd_chk("rdwr_after", 6'd6, 32'h77, 1'b0);

    // snapshot of another counter does not affect a live high read
    rd_chk("c0_lo_cap", 6'd0, 32'd15, 1'b0);
    rd_chk("c1_hi_live", 6'd3, 32'd2, 1'b0);

    // 64-bit wrap on channel 4
    wr(6'd8, 32'hFFFF_FFFF);
    wr(6'd9, 32'hFFFF_FFFF);
    inc_i = 5'b10000;
    tick();
    inc_i = '0;
    check("irq_not_yet", 64'(irq), 64'd0);
    tick();
    check("irq_rise", 64'(irq), 64'(OVF_EN));
    rd_chk("c4_wrap_lo", 6'd8, 32'h0, 1'b0);
    rd_chk("c4_wrap_hi", 6'd9, 32'h0, 1'b0);
    rd_chk("ovf_set", 6'd11, OVF_EN ? 32'h10 : 32'h0, 1'b0);
    wr(6'd11, 32'h10);
    check("irq_hold", 64'(irq), 64'(OVF_EN));
    tick();
    check("irq_fall", 64'(irq), 64'd0);
    rd_chk("ovf_clr", 6'd11, 32'h0, 1'b0);

    // async reset mid-count drops the pending read response
    inc_i = 5'b11111;
    repeat (3) tick();
    rd_en = 1'b1; rd_addr = 6'd0;
    tick();
    rd_en = 1'b0;
    check("pre_rst.valid", 64'(rd_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.valid", 64'(rd_valid), 64'd0);
    check("async_rst.data", 64'(rd_data), 64'd0);
    check("async_rst.irq", 64'(irq), 64'd0);
    inc_i = '0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 12; a++) rd_chk($sformatf("post_rst_a%0d", a), 6'(a), 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
